// File: rtl/frc_timer_pkg.sv
// Shared definitions for the machine timer: register word map, CTRL field
// positions and reset constants.
package frc_timer_pkg;

  typedef enum logic [2:0] {
    FRC_MTIME_LO = 3'd0,
    FRC_MTIME_HI = 3'd1,
    FRC_CMP_LO   = 3'd2,
    FRC_CMP_HI   = 3'd3,
    FRC_CTRL     = 3'd4,
    FRC_STATUS   = 3'd5,
    FRC_RSVD6    = 3'd6,
    FRC_RSVD7    = 3'd7
  } frc_word_e;

  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // The window is 32 bytes, so only address bits [31:5] take part in the match.
  function automatic logic frc_in_window(input logic [31:0] adr,
                                         input logic [31:0] base);
    return adr[31:5] == base[31:5];
  endfunction

endpackage

// File: rtl/frc_timer_if.sv
// CPU I/O bus as seen by the machine timer: one-cycle strobes, registered read data.
interface frc_timer_if;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_adr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_rvalid;

  modport master (
    output io_we, io_re, io_adr, io_wdata,
    input  io_rdata, io_rvalid
  );

  modport slave (
    input  io_we, io_re, io_adr, io_wdata,
    output io_rdata, io_rvalid
  );
endinterface

// File: rtl/frc_prescaler.sv
// Prescaler for the machine timer: emits one tick every presc+1 enabled,
// non-halted cycles.
module frc_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               halt,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               run;

  always_comb begin
    run  = en & ~halt;
    tick = run && (presc_cnt == presc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (clr || tick) begin
      presc_cnt <= '0;
    end else if (run) begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/frc_timer.sv
// Memory-mapped machine timer: 64-bit mtime, armed 64-bit compare, and the
// registered mtime >= mtimecmp level feeding the CSR interrupt logic.
module frc_timer
  import frc_timer_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'hC000_0100,
  parameter int unsigned PRESC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  frc_timer_if.slave       io,
  input  logic             cpu_halt,
  output logic             frc_cntr_val_leq
);

  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic [31:0]        hi_shadow;
  logic               cmp_armed;
  logic               ctrl_en;
  logic [PRESC_W-1:0] ctrl_presc;

  logic               hit;
  logic               wr;
  logic               rd;
  frc_word_e          word;
  logic               tick;
  logic [31:0]        ctrl_rd;
  logic [31:0]        rd_mux;
  logic               unused_adr;

  always_comb begin
    hit  = frc_in_window(io.io_adr, IO_BASE);
    wr   = io.io_we & hit;
    rd   = io.io_re & hit;
    word = frc_word_e'(io.io_adr[4:2]);
  end

  assign unused_adr = &{1'b0, io.io_adr[1:0]};

  frc_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl_en),
    .halt  (cpu_halt),
    .presc (ctrl_presc),
    .clr   (wr && (word == FRC_CTRL)),
    .tick  (tick)
  );

  always_comb begin
    ctrl_rd                              = '0;
    ctrl_rd[CTRL_EN]                     = ctrl_en;
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_W]   = ctrl_presc;
  end

  // Read data is taken from the pre-write state, so a simultaneous write
  // never shows through on the same access.
  always_comb begin
    rd_mux = '0;
    case (word)
      FRC_MTIME_LO: rd_mux = mtime[31:0];
      FRC_MTIME_HI: rd_mux = hi_shadow;
      FRC_CMP_LO:   rd_mux = mtimecmp[31:0];
      FRC_CMP_HI:   rd_mux = mtimecmp[63:32];
      FRC_CTRL:     rd_mux = ctrl_rd;
      FRC_STATUS:   rd_mux = {30'd0, cmp_armed, frc_cntr_val_leq};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io.io_rdata  <= '0;
      io.io_rvalid <= 1'b0;
      hi_shadow    <= '0;
    end else begin
      io.io_rvalid <= rd;
      if (rd) begin
        io.io_rdata <= rd_mux;
        if (word == FRC_MTIME_LO) begin
          hi_shadow <= mtime[63:32];
        end
      end
    end
  end

  // A software write to either mtime half wins over a tick; the untouched
  // half holds and no carry is propagated that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr && (word == FRC_MTIME_LO)) begin
      mtime[31:0] <= io.io_wdata;
    end else if (wr && (word == FRC_MTIME_HI)) begin
      mtime[63:32] <= io.io_wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp   <= MTIMECMP_RST;
      cmp_armed  <= 1'b1;
      ctrl_en    <= 1'b0;
      ctrl_presc <= '0;
    end else if (wr) begin
      case (word)
        FRC_CMP_LO: begin
          mtimecmp[31:0] <= io.io_wdata;
          cmp_armed      <= 1'b0;
        end
        FRC_CMP_HI: begin
          mtimecmp[63:32] <= io.io_wdata;
          cmp_armed       <= 1'b1;
        end
        FRC_CTRL: begin
          ctrl_en    <= io.io_wdata[CTRL_EN];
          ctrl_presc <= io.io_wdata[CTRL_PRESC_LSB +: PRESC_W];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frc_cntr_val_leq <= 1'b0;
    end else begin
      frc_cntr_val_leq <= cmp_armed && (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_frc_timer.sv
// Directed bench for frc_timer: reads push expected data into a scoreboard
// queue, a monitor pops and compares on each io_rvalid.
module tb_frc_timer;
  import frc_timer_pkg::*;

  localparam logic [31:0] BASE = 32'hC000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_halt = 1'b0;
  logic leq;

  frc_timer_if bus();

  frc_timer #(
    .IO_BASE (BASE),
    .PRESC_W (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .io               (bus),
    .cpu_halt         (cpu_halt),
    .frc_cntr_val_leq (leq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.io_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rdata %h expected no response", bus.io_rdata);
      end else begin
        e = exp_q.pop_front();
        check(e.name, bus.io_rdata, e.val);
      end
    end
  end

  function automatic logic [31:0] A(input int unsigned w);
    return BASE + 32'(w * 4);
  endfunction

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    bus.io_we = 1'b1; bus.io_adr = adr; bus.io_wdata = d;
    @(negedge clk);
    bus.io_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] adr, input string name, input logic [31:0] exp,
                    input bit resp = 1'b1);
    exp_t e;
    if (resp) begin
      e.name = name; e.val = exp;
      exp_q.push_back(e);
    end
    bus.io_re = 1'b1; bus.io_adr = adr;
    @(negedge clk);
    bus.io_re = 1'b0;
  endtask

  task automatic rw(input logic [31:0] adr, input logic [31:0] d, input string name,
                    input logic [31:0] exp);
    exp_t e;
    e.name = name; e.val = exp;
    exp_q.push_back(e);
    bus.io_we = 1'b1; bus.io_re = 1'b1; bus.io_adr = adr; bus.io_wdata = d;
    @(negedge clk);
    bus.io_we = 1'b0; bus.io_re = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] rst_exp [8] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h0, 32'h2, 32'h0, 32'h0};
  logic [31:0] presc_exp [5] = '{32'd10, 32'd10, 32'd10, 32'd10, 32'd11};

  initial begin
    bus.io_we = 1'b0; bus.io_re = 1'b0; bus.io_adr = '0; bus.io_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_leq", {31'd0, leq}, 32'd0);
    for (int i = 0; i < 8; i++) rd(A(i), $sformatf("rst_word%0d", i), rst_exp[i]);

    // Prescale 3: ticks on every 4th cycle after the CTRL write
    wr(A(FRC_CTRL), 32'h0000_0301);
    idle(40);
    for (int i = 0; i < 5; i++) rd(A(FRC_MTIME_LO), $sformatf("presc_lo%0d", i), presc_exp[i]);
    rd(A(FRC_MTIME_HI), "presc_hi", 32'd0);

    // Wrap with coherent LO/HI read
    wr(A(FRC_CTRL), 32'h0);
    wr(A(FRC_MTIME_HI), 32'h0);
    wr(A(FRC_MTIME_LO), 32'hFFFF_FFFE);
    wr(A(FRC_CTRL), 32'h1);
    idle(3);
    rd(A(FRC_MTIME_LO), "wrap_lo", 32'd1);
    rd(A(FRC_MTIME_HI), "wrap_hi", 32'd1);

    // HI read after the carry still returns the shadow taken at the LO read
    wr(A(FRC_CTRL), 32'h0);
    wr(A(FRC_MTIME_HI), 32'h0);
    wr(A(FRC_MTIME_LO), 32'hFFFF_FFFE);
    wr(A(FRC_CTRL), 32'h1);
    rd(A(FRC_MTIME_LO), "shadow_lo", 32'hFFFF_FFFE);
    idle(1);
    rd(A(FRC_MTIME_HI), "shadow_hi", 32'd0);
    rd(A(FRC_MTIME_LO), "shadow_lo2", 32'd1);
    rd(A(FRC_MTIME_HI), "shadow_hi2", 32'd1);

    // Compare arming and leq timing
    wr(A(FRC_CTRL), 32'h0);
    wr(A(FRC_MTIME_HI), 32'h0);
    wr(A(FRC_MTIME_LO), 32'h0);
    wr(A(FRC_CMP_LO), 32'd20);
    rd(A(FRC_STATUS), "status_disarmed", 32'h0);
    wr(A(FRC_CMP_HI), 32'd0);
    rd(A(FRC_STATUS), "status_armed", 32'h2);
    wr(A(FRC_CTRL), 32'h1);
    idle(19);
    check("leq_at19", {31'd0, leq}, 32'd0);
    idle(1);
    check("leq_at20", {31'd0, leq}, 32'd0);
    idle(1);
    check("leq_rise", {31'd0, leq}, 32'd1);
    wr(A(FRC_CMP_LO), 32'd100);
    check("leq_hold", {31'd0, leq}, 32'd1);
    idle(1);
    check("leq_fall", {31'd0, leq}, 32'd0);
    rd(A(FRC_STATUS), "status_cmplo", 32'h0);
    idle(100);
    check("leq_disarmed", {31'd0, leq}, 32'd0);
    wr(A(FRC_CMP_HI), 32'd0);
    check("leq_rearm_edge", {31'd0, leq}, 32'd0);
    idle(1);
    check("leq_rearmed", {31'd0, leq}, 32'd1);
    rd(A(FRC_STATUS), "status_both", 32'h3);

    // CTRL field masking and simultaneous write+read
    rw(A(FRC_CTRL), 32'h0000_0501, "rw_ctrl_old", 32'h0000_0001);
    rd(A(FRC_CTRL), "ctrl_new", 32'h0000_0501);
    wr(A(FRC_CTRL), 32'hFFFF_FFFE);
    rd(A(FRC_CTRL), "ctrl_mask", 32'h0000_FF00);

    // Halt freezes counting
    wr(A(FRC_CTRL), 32'h0);
    wr(A(FRC_MTIME_HI), 32'h0);
    wr(A(FRC_MTIME_LO), 32'd1000);
    cpu_halt = 1'b1;
    wr(A(FRC_CTRL), 32'h1);
    idle(4);
    rd(A(FRC_MTIME_LO), "halt_lo", 32'd1000);
    rd(A(FRC_MTIME_HI), "halt_hi", 32'd0);
    cpu_halt = 1'b0;
    rd(A(FRC_MTIME_LO), "unhalt_lo", 32'd1000);
    idle(2);
    rd(A(FRC_MTIME_LO), "unhalt_run", 32'd1003);

    // Writes beat a coincident tick
    wr(A(FRC_MTIME_LO), 32'd500);
    rd(A(FRC_MTIME_LO), "prio_lo", 32'd500);
    wr(A(FRC_MTIME_HI), 32'd7);
    rd(A(FRC_MTIME_LO), "prio_lo_hold", 32'd501);
    rd(A(FRC_MTIME_HI), "prio_hi", 32'd7);

    // Out-of-window and reserved accesses
    rd(BASE + 32'h20, "", 32'h0, 1'b0);
    wr(BASE + 32'h28, 32'h0);
    rd(A(FRC_CMP_LO), "oow_cmp_lo", 32'd100);
    rd(A(FRC_STATUS), "oow_status", 32'h3);
    wr(A(FRC_RSVD6), 32'h1234_5678);
    rd(A(FRC_RSVD6), "rsvd6", 32'h0);
    rd(A(FRC_RSVD7), "rsvd7", 32'h0);

    // Reset while leq is high and the compare is disarmed
    wr(A(FRC_CMP_LO), 32'hFFFF_FFFF);
    check("leq_before_rst", {31'd0, leq}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("leq_after_rst", {31'd0, leq}, 32'd0);
    rd(A(FRC_STATUS), "rst2_status", 32'h2);
    rd(A(FRC_MTIME_LO), "rst2_lo", 32'h0);
    rd(A(FRC_MTIME_HI), "rst2_hi", 32'h0);
    rd(A(FRC_CMP_LO), "rst2_cmp_lo", 32'hFFFF_FFFF);
    rd(A(FRC_CTRL), "rst2_ctrl", 32'h0);

    idle(3);
    check("pending_reads", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frc_timer.md
Name: frc_timer

Overview:
- Machine-timer block, memory-mapped on the CPU I/O bus.
- Holds a 64-bit free-running counter (mtime), a 64-bit compare register (mtimecmp) and a prescaler.
- Drives frc_cntr_val_leq into the CSR array. That signal feeds mip.MTIP and the mcause code-7 timer interrupt path.
- Sits directly upstream of the CSR/interrupt logic.

Parameters:
- IO_BASE, 32'hC000_0100, byte base address of the register window; eight 32-bit words.
- PRESC_W, 8, width of the prescaler compare field.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- io_we  in  1  write strobe, one cycle
- io_re  in  1  read strobe, one cycle
- io_adr  in  32  byte address; bits [4:2] select the word when [31:5] match IO_BASE[31:5]
- io_wdata  in  32  write data
- io_rdata  out  32  read data, registered
- io_rvalid  out  1  pulses one cycle after an accepted io_re
- cpu_halt  in  1  debug halt; freezes counting while high
- frc_cntr_val_leq  out  1  level; mtimecmp <= mtime and the compare is armed

Behaviour:
- Reset (rst high at a clk edge):
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - ctrl = 0: EN = 0, PRESC = 0.
  - presc_cnt = 0, hi_shadow = 0, cmp_armed = 1.
  - io_rdata = 0, io_rvalid = 0, frc_cntr_val_leq = 0.
  - Reset mid-sequence discards any pending hi_shadow or disarm state.
- Word map (offset → register):
  - 0 MTIME_LO (RW)
  - 1 MTIME_HI (RW; a read returns hi_shadow)
  - 2 CMP_LO (RW)
  - 3 CMP_HI (RW)
  - 4 CTRL (RW): bit0 EN, bits[8+PRESC_W-1:8] PRESC; other bits read 0.
  - 5 STATUS (RO): bit0 = frc_cntr_val_leq, bit1 = cmp_armed.
  - 6, 7 reserved: read 0, writes ignored.
- Tick generation:
  - When EN = 1 and cpu_halt = 0, presc_cnt increments each cycle.
  - When presc_cnt == PRESC, tick = 1 for that cycle and presc_cnt returns to 0.
  - PRESC = 0 ticks every cycle; PRESC = N ticks every N+1 cycles.
  - Any CTRL write clears presc_cnt.
  - With EN = 0 or cpu_halt = 1, presc_cnt and mtime hold.
- Counter:
  - mtime increments by 1 on each tick; 64-bit wrap FFFF_FFFF_FFFF_FFFF → 0 with no flag.
  - A write to MTIME_LO or MTIME_HI in the same cycle as a tick takes priority: the written half takes the wdata value, and the other half holds, with no increment or carry that cycle.
- Atomic 64-bit read:
  - A read of MTIME_LO returns the current low word and, in the same cycle, latches mtime[63:32] into hi_shadow.
  - A read of MTIME_HI returns hi_shadow.
  - Software reads LO first, then HI.
- Compare arming (glitch-free 64-bit update):
  - Writing CMP_LO updates cmp[31:0] and clears cmp_armed.
  - Writing CMP_HI updates cmp[63:32] and sets cmp_armed.
  - Writing CMP_HI alone leaves cmp_armed set.
- Output:
  - frc_cntr_val_leq is registered: it becomes 1 on the clock edge after (cmp_armed & mtime >= mtimecmp) becomes true, using the mtime and mtimecmp values of that cycle.
  - The comparison is unsigned 64-bit.
  - The output stays level until the condition is false; there is no latch or clear-on-read.
  - It is independent of EN, so a frozen counter at or beyond compare keeps the level asserted.
- Bus:
  - Reads have one-cycle latency. io_rdata holds its value until the next accepted read.
  - io_we and io_re in the same cycle: the write is performed and the read returns the pre-write value.
  - Addresses outside the window are ignored: no io_rvalid, no state change.

Decomposition:
- Shared package frc_timer_pkg holds:
  - word offsets FRC_MTIME_LO..FRC_STATUS (3-bit);
  - CTRL bit positions CTRL_EN and CTRL_PRESC_LSB;
  - MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF.
- One sub-module, frc_prescaler (presc_cnt and tick; inputs en, halt, presc, clr), is natural.
- Counter, compare and bus decode stay in frc_timer.

Test Plan:
- Reset: hold rst 2 cycles → every register reads 0 except CMP_LO and CMP_HI (FFFF_FFFF each); STATUS = 2'b10; frc_cntr_val_leq = 0.
- Prescale: write CTRL = 0x0000_0301 (EN, PRESC = 3); wait 40 cycles → MTIME_LO = 10 (±1 for write alignment); ticks exactly every 4 cycles.
- Wrap/atomic read: write MTIME_HI = 0, MTIME_LO = FFFF_FFFE with PRESC = 0, EN = 1; after 3 ticks read LO then HI → LO = 1, HI = 1. Read LO before the carry and HI after it → HI returns the shadowed 0.
- Compare: mtime = 0, EN = 1, PRESC = 0; write CMP_LO = 20 (disarms), CMP_HI = 0 (arms) → leq rises on the edge after mtime reaches 20. Write CMP_LO = 100 → leq falls the next cycle and stays 0 until CMP_HI is written.
- Halt/priority: assert cpu_halt for 5 cycles → mtime constant. A MTIME_LO write coinciding with a tick → value equals wdata, not wdata+1.
- Reset mid-operation: assert rst while leq = 1 and cmp_armed = 0 → next cycle leq = 0, cmp_armed = 1, mtime = 0.
